// File: rtl/lsu_pkg.sv
// Shared constants, state encoding and decode helpers for the load/store unit.
package lsu_pkg;

  localparam int unsigned XLEN = 32;

  // Load funct3 encodings (stores share the low two bits).
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Memory width codes; W_NONE means the memory port is idle.
  localparam logic [3:0] W_NONE = 4'd0;
  localparam logic [3:0] W_BYTE = 4'd1;
  localparam logic [3:0] W_HALF = 4'd2;
  localparam logic [3:0] W_WORD = 4'd4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Access size from funct3[1:0]; the reserved size decodes to W_NONE.
  function automatic logic [3:0] width_decode(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   width_decode = W_BYTE;
      2'b01:   width_decode = W_HALF;
      2'b10:   width_decode = W_WORD;
      default: width_decode = W_NONE;
    endcase
  endfunction

  // Reserved size, or an unsigned variant on a store.
  function automatic logic funct3_illegal(input logic write, input logic [2:0] funct3);
    funct3_illegal = (funct3[1:0] == 2'b11) || (write && funct3[2]);
  endfunction

endpackage

// File: rtl/load_store_unit_load_extend.sv
// Sign/zero extension of right-justified load data according to funct3.
module load_extend
  import lsu_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] data,
  output logic [XLEN-1:0] data_ext
);

  // Pick the extension rule from the load type; LW passes through.
  always_comb begin
    data_ext = data;
    case (funct3)
      F3_LB:   data_ext = {{24{data[7]}}, data[7:0]};
      F3_LH:   data_ext = {{16{data[15]}}, data[15:0]};
      F3_LBU:  data_ext = {24'd0, data[7:0]};
      F3_LHU:  data_ext = {16'd0, data[15:0]};
      default: data_ext = data;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request per handshake, one memory access cycle,
// then a held response carrying extended load data or an error flag.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter logic [XLEN-1:0] ADDR_LIMIT        = 32'h400,
  parameter int unsigned     MEM_LATENCY_FIXED = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_error,
  output logic [XLEN-1:0] mem_address,
  output logic [3:0]      mem_width,
  output logic            mem_write_en,
  output logic [XLEN-1:0] mem_data_in,
  input  logic [XLEN-1:0] mem_data_out
);

  // Only a single-cycle registered memory read is supported.
  if (MEM_LATENCY_FIXED != 1) begin : g_bad_latency
    $error("load_store_unit supports MEM_LATENCY_FIXED == 1 only");
  end

  state_t          state;
  state_t          state_next;
  logic            accept;
  logic            access_done;
  logic            resp_done;
  logic [3:0]      req_width;
  logic            req_err;
  logic [2:0]      funct3_q;
  logic            write_q;
  logic            error_q;
  logic [XLEN-1:0] load_data;

  // Request error check: illegal funct3, misalignment or out-of-range address.
  always_comb begin
    req_width = width_decode(req_funct3);
    req_err   = funct3_illegal(req_write, req_funct3)
              || ((req_width == W_HALF) && req_addr[0])
              || ((req_width == W_WORD) && (req_addr[1:0] != 2'b00))
              || (req_addr >= ADDR_LIMIT);
  end

  assign req_ready = (state == IDLE) && !reset;

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic and per-cycle control strobes.
  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    access_done = 1'b0;
    resp_done   = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept     = 1'b1;
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        access_done = 1'b1;
        state_next  = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          resp_done  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  load_extend u_load_extend (
    .funct3   (funct3_q),
    .data     (mem_data_out),
    .data_ext (load_data)
  );

  // Datapath: drive the memory port for the access cycle, then latch the response.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_address  <= '0;
      mem_width    <= W_NONE;
      mem_write_en <= 1'b0;
      mem_data_in  <= '0;
      funct3_q     <= '0;
      write_q      <= 1'b0;
      error_q      <= 1'b0;
      resp_valid   <= 1'b0;
      resp_rdata   <= '0;
      resp_error   <= 1'b0;
    end else begin
      if (accept) begin
        mem_address  <= req_addr;
        mem_data_in  <= req_wdata;
        mem_width    <= req_err ? W_NONE : req_width;
        mem_write_en <= req_write && !req_err;
        funct3_q     <= req_funct3;
        write_q      <= req_write;
        error_q      <= req_err;
      end
      if (access_done) begin
        mem_width    <= W_NONE;
        mem_write_en <= 1'b0;
        resp_valid   <= 1'b1;
        resp_rdata   <= (write_q || error_q) ? '0 : load_data;
        resp_error   <= error_q;
      end
      if (resp_done) begin
        resp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed plus randomized bench for load_store_unit with a byte-array memory
// and an independent byte-level reference model.
module tb_load_store_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] mem_address;
  logic [3:0]  mem_width;
  logic        mem_write_en;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;

  int checks = 0;
  int errors = 0;
  int width_cycles = 0;
  int we_cycles = 0;

  logic [7:0] mem     [1024];
  logic [7:0] ref_mem [1024];

  load_store_unit dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_error   (resp_error),
    .mem_address  (mem_address),
    .mem_width    (mem_width),
    .mem_write_en (mem_write_en),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out)
  );

  always #5 clock = ~clock;

  // Memory read path: data for the presented address, right-justified, zero-filled.
  always_comb begin
    mem_data_out = 32'd0;
    for (int i = 0; i < 4; i++)
      if (32'(i) < 32'(mem_width))
        mem_data_out[8*i +: 8] = mem[mem_address[9:0] + 10'(i)];
  end

  // Memory write path plus activity counters.
  always @(posedge clock) begin
    if (mem_write_en)
      for (int i = 0; i < 4; i++)
        if (32'(i) < 32'(mem_width))
          mem[mem_address[9:0] + 10'(i)] <= mem_data_in[8*i +: 8];
    if (mem_width != 4'd0) width_cycles <= width_cycles + 1;
    if (mem_write_en) we_cycles <= we_cycles + 1;
  end

  initial begin
    #500000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic int unsigned ref_width(input logic [2:0] f3);
    case (f3[1:0])
      2'd0: return 1;
      2'd1: return 2;
      2'd2: return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit ref_error(input bit w, input logic [2:0] f3, input logic [31:0] a);
    int unsigned wd = ref_width(f3);
    if (wd == 0) return 1;
    if (w && f3[2]) return 1;
    if ((a % wd) != 0) return 1;
    if (a >= 32'h400) return 1;
    return 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    int unsigned wd = ref_width(f3);
    longint v = 0;
    for (int i = 0; i < 4; i++)
      if (i < int'(wd)) v = v + (longint'(ref_mem[a[9:0] + 10'(i)]) << (8 * i));
    if (!f3[2] && wd < 4 && v >= (longint'(1) << (8 * wd - 1)))
      v = v - (longint'(1) << (8 * wd)) + (longint'(1) << 32);
    return 32'(v);
  endfunction

  // One full transaction from IDLE back to IDLE; entered and left at posedge+1.
  task automatic do_op(input bit w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input int stall);
    bit          err = ref_error(w, f3, a);
    int unsigned wd = ref_width(f3);
    logic [31:0] exp_rd = (w || err) ? 32'd0 : ref_load(f3, a);
    int          wc0 = width_cycles;
    int          we0 = we_cycles;
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = d;
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    @(posedge clock); #1;
    req_valid = 1'b0;
    chk("access_width", 32'(mem_width), err ? 32'd0 : 32'(wd));
    chk("access_we", 32'(mem_write_en), 32'(w && !err));
    chk("access_addr", mem_address, a);
    if (w && !err) chk("access_wdata", mem_data_in, d);
    chk("access_resp_valid", 32'(resp_valid), 32'd0);
    @(posedge clock); #1;
    chk("resp_valid", 32'(resp_valid), 32'd1);
    chk("resp_rdata", resp_rdata, exp_rd);
    chk("resp_error", 32'(resp_error), 32'(err));
    chk("resp_width_idle", 32'(mem_width), 32'd0);
    chk("resp_req_ready", 32'(req_ready), 32'd0);
    for (int s = 0; s < stall; s++) begin
      @(posedge clock); #1;
      chk("stall_valid", 32'(resp_valid), 32'd1);
      chk("stall_rdata", resp_rdata, exp_rd);
      chk("stall_error", 32'(resp_error), 32'(err));
      chk("stall_req_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clock); #1;
    resp_ready = 1'b0;
    chk("post_resp_valid", 32'(resp_valid), 32'd0);
    chk("post_req_ready", 32'(req_ready), 32'd1);
    chk("width_cycle_count", 32'(width_cycles - wc0), err ? 32'd0 : 32'd1);
    chk("we_cycle_count", 32'(we_cycles - we0), 32'(w && !err));
    if (w && !err)
      for (int i = 0; i < 4; i++)
        if (i < int'(wd)) ref_mem[a[9:0] + 10'(i)] = d[8*i +: 8];
  endtask

  initial begin
    logic [31:0] ra;
    logic [2:0]  rf;
    bit          rw;
    for (int i = 0; i < 1024; i++) begin
      mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end

    // Reset values.
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_error", 32'(resp_error), 32'd0);
    chk("rst_mem_address", mem_address, 32'd0);
    chk("rst_mem_width", 32'(mem_width), 32'd0);
    chk("rst_mem_we", 32'(mem_write_en), 32'd0);
    chk("rst_mem_data_in", mem_data_in, 32'd0);
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0;
    #1;
    chk("after_rst_req_ready", 32'(req_ready), 32'd1);

    // Word store then load.
    do_op(1, 3'b010, 32'h10, 32'hDEADBEEF, 0);
    do_op(0, 3'b010, 32'h10, 32'h0, 0);
    // Byte store, signed and unsigned byte loads.
    do_op(1, 3'b000, 32'h21, 32'h80, 0);
    do_op(0, 3'b000, 32'h21, 32'h0, 0);
    do_op(0, 3'b100, 32'h21, 32'h0, 0);
    // Half store, signed and unsigned half loads.
    do_op(1, 3'b001, 32'h22, 32'h8001, 0);
    do_op(0, 3'b001, 32'h22, 32'h0, 0);
    do_op(0, 3'b101, 32'h22, 32'h0, 0);
    // Error cases: misaligned half/word, out-of-range, illegal funct3.
    do_op(0, 3'b001, 32'h23, 32'h0, 0);
    do_op(0, 3'b010, 32'h12, 32'h0, 0);
    do_op(1, 3'b010, 32'h400, 32'h11223344, 0);
    do_op(0, 3'b011, 32'h10, 32'h0, 0);
    do_op(1, 3'b100, 32'h20, 32'h55, 0);
    // Boundary: last legal byte and word.
    do_op(1, 3'b010, 32'h3FC, 32'hA5A55A5A, 0);
    do_op(0, 3'b000, 32'h3FF, 32'h0, 0);
    // Response backpressure.
    do_op(0, 3'b010, 32'h10, 32'h0, 3);

    // Reset during the access cycle of a store.
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h10; req_wdata = 32'h12345678;
    @(posedge clock); #1;
    req_valid = 1'b0;
    chk("abort_access_we", 32'(mem_write_en), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("abort_we_drop", 32'(mem_write_en), 32'd0);
    chk("abort_width_drop", 32'(mem_width), 32'd0);
    chk("abort_req_ready", 32'(req_ready), 32'd0);
    chk("abort_resp_valid", 32'(resp_valid), 32'd0);
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      chk("abort_no_resp", 32'(resp_valid), 32'd0);
    end
    chk("abort_idle", 32'(req_ready), 32'd1);
    do_op(0, 3'b010, 32'h10, 32'h0, 0);

    // Randomized traffic over a small window plus boundary addresses.
    for (int n = 0; n < 60; n++) begin
      rw = bit'($urandom_range(0, 1));
      rf = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0:       ra = 32'h3F8 + 32'($urandom_range(0, 15));
        1:       ra = $urandom;
        default: ra = 32'h40 + 32'($urandom_range(0, 15));
      endcase
      if (!rw && $urandom_range(0, 1) == 1) rf = {1'($urandom_range(0, 1)), 2'($urandom_range(0, 2))};
      do_op(rw, rf, ra, $urandom, int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
